// File: rtl/traffic_pkg.sv
// Shared constants and types for the traffic countdown display: segment codes,
// the digit decode table, the conversion FSM states and the scan digit indices.
package traffic_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a} patterns for the digits 0..9
  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam logic [1:0] DIG_M_ONES = 2'd0;
  localparam logic [1:0] DIG_M_TENS = 2'd1;
  localparam logic [1:0] DIG_C_ONES = 2'd2;
  localparam logic [1:0] DIG_C_TENS = 2'd3;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    if (nib <= 4'd9) return SEG_TABLE[nib];
    return SEG_BLANK;
  endfunction

endpackage

// File: rtl/bin2bcd8.sv
// One 8-bit sequential double-dabble engine; load clears scratch and captures bin,
// each shift cycle adds 3 to nibbles >= 5 and then shifts left; done after 8 shifts.
module bin2bcd8
  import traffic_pkg::*;
(
  input  logic        clk,
  input  logic        set,
  input  logic        load,
  input  logic        shift,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        done
);

  logic [7:0]  sh;
  logic [11:0] scratch;
  logic [11:0] adj;
  logic [3:0]  cnt;

  always_comb begin
    adj = scratch;
    if (scratch[3:0]  >= 4'd5) adj[3:0]  = scratch[3:0]  + 4'd3;
    if (scratch[7:4]  >= 4'd5) adj[7:4]  = scratch[7:4]  + 4'd3;
    if (scratch[11:8] >= 4'd5) adj[11:8] = scratch[11:8] + 4'd3;
  end

  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      sh      <= '0;
      scratch <= '0;
      cnt     <= '0;
    end else if (load) begin
      sh      <= bin;
      scratch <= '0;
      cnt     <= '0;
    end else if (shift && cnt != 4'd8) begin
      scratch <= {adj[10:0], sh[7]};
      sh      <= {sh[6:0], 1'b0};
      cnt     <= cnt + 4'd1;
    end
  end

  assign bcd  = scratch;
  assign done = (cnt == 4'd8);

endmodule

// File: rtl/traffic_display.sv
// Converts the two road countdowns to BCD every 10 cycles and scans them onto four
// common-anode digits; optional macro TRAFFIC_DISP_LZB_EN blanks a zero tens digit.
module traffic_display
  import traffic_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       set,
  input  logic [7:0] count,
  input  logic [7:0] count_c,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic [7:0] bcd_m,
  output logic [7:0] bcd_c,
  output logic       ovf_m,
  output logic       ovf_c
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  conv_state_t state;
  logic [2:0]  bit_cnt;
  logic        load, shift;
  logic [11:0] res_m, res_c;
  logic        done_m, done_c;

  assign load  = (state == IDLE);
  assign shift = (state == SHIFT);

  bin2bcd8 u_conv_m (
    .clk(clk), .set(set), .load(load), .shift(shift),
    .bin(count), .bcd(res_m), .done(done_m)
  );

  bin2bcd8 u_conv_c (
    .clk(clk), .set(set), .load(load), .shift(shift),
    .bin(count_c), .bcd(res_c), .done(done_c)
  );

  // Both engines run in lockstep; results are committed only as a whole in DONE
  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bcd_m   <= '0;
      bcd_c   <= '0;
      ovf_m   <= 1'b0;
      ovf_c   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= DONE;
        end
        DONE: begin
          if (done_m && done_c) begin
            bcd_m <= res_m[7:0];
            bcd_c <= res_c[7:0];
            ovf_m <= (res_m[11:8] != 4'd0) || (res_m[7:4] > 4'd9);
            ovf_c <= (res_c[11:8] != 4'd0) || (res_c[7:4] > 4'd9);
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic          lit;
  logic [3:0]    nib;
  logic          road_ovf;
  logic          is_tens;
  logic [6:0]    seg_next;

  always_comb begin
    nib      = bcd_m[3:0];
    road_ovf = ovf_m;
    is_tens  = 1'b0;
    case (idx)
      DIG_M_ONES: begin nib = bcd_m[3:0]; road_ovf = ovf_m; end
      DIG_M_TENS: begin nib = bcd_m[7:4]; road_ovf = ovf_m; is_tens = 1'b1; end
      DIG_C_ONES: begin nib = bcd_c[3:0]; road_ovf = ovf_c; end
      default:    begin nib = bcd_c[7:4]; road_ovf = ovf_c; is_tens = 1'b1; end
    endcase

    seg_next = seg_decode(nib);
    if (road_ovf) begin
      seg_next = SEG_DASH;
    end
`ifdef TRAFFIC_DISP_LZB_EN
    else if (is_tens && nib == 4'd0) begin
      seg_next = SEG_BLANK;
    end
`else
    else if (is_tens) begin
      seg_next = seg_decode(nib);
    end
`endif
  end

  // lit delays the first lit digit by one cycle after reset release
  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      presc <= '0;
      idx   <= DIG_M_ONES;
      lit   <= 1'b0;
      an    <= 4'b1111;
      seg   <= SEG_BLANK;
    end else begin
      if (presc == PRESC_LAST) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + 1'b1;
      end
      lit <= 1'b1;
      an  <= lit ? ~(4'b0001 << idx) : 4'b1111;
      seg <= lit ? seg_next : SEG_BLANK;
    end
  end

endmodule
